// File: rtl/lcd_frame_scheduler.sv
// lcd_frame_scheduler
//
// Walks the LCD raster one pixel at a time and hands each rendered pixel to
// the LCD writer over a valid/ready handshake. The cube state used by the
// renderer is frozen for a whole frame so the picture never tears.
//
// Ports:
//   clock         sole clock, all state updates on the rising edge
//   reset         synchronous, active-high reset
//   cube_state    live 144-bit cube state from the input logic
//   state_valid   one-cycle strobe: cube_state holds a new value
//   start         request one frame (honoured only while idle)
//   auto_refresh  when high, a new frame begins as soon as one completes
//   x, y          pixel coordinate presented to the square renderer
//   render_state  frame-stable cube state presented to the renderer
//   pixel_in      RGB565 from the renderer (combinational in x, y, render_state)
//   pixel_data    registered pixel towards the LCD writer
//   pixel_valid   pixel_data is valid
//   pixel_ready   LCD writer accepts pixel_data
//   pixel_first   qualifies pixel (0,0)
//   pixel_eol     qualifies the last pixel of a line
//   busy          high whenever a frame is in progress
//   frame_done    one-cycle pulse when a frame has been fully accepted
//   frame_count   completed frames, wraps 255 -> 0
module lcd_frame_scheduler #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [143:0] cube_state,
    input  logic         state_valid,
    input  logic         start,
    input  logic         auto_refresh,
    output logic [8:0]   x,
    output logic [7:0]   y,
    output logic [143:0] render_state,
    input  logic [15:0]  pixel_in,
    output logic [15:0]  pixel_data,
    output logic         pixel_valid,
    input  logic         pixel_ready,
    output logic         pixel_first,
    output logic         pixel_eol,
    output logic         busy,
    output logic         frame_done,
    output logic [7:0]   frame_count
);

    localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
    localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [143:0] shadow;
    logic         frame_start;
    logic         pixel_load;
    logic         drain_ack;
    logic         last_pixel;

    assign last_pixel = (x == X_LAST) && (y == Y_LAST);
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. Besides the next state this produces three strobes
    // that steer the datapath: frame_start (restart the raster and latch a
    // new render_state), pixel_load (capture the renderer output) and
    // drain_ack (the final pixel has been accepted).
    // In DRAIN pixel_valid is always high, so pixel_ready alone is the
    // handshake for the last pixel.
    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        pixel_load  = 1'b0;
        drain_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (start || auto_refresh) begin
                    frame_start = 1'b1;
                    next_state  = STREAM;
                end
            end
            STREAM: begin
                if (!pixel_valid || pixel_ready) begin
                    pixel_load = 1'b1;
                    if (last_pixel) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pixel_ready) begin
                    drain_ack = 1'b1;
                    if (auto_refresh) begin
                        frame_start = 1'b1;
                        next_state  = STREAM;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath. The shadow register tracks every state_valid strobe, but
    // render_state only moves at a frame start; a strobe arriving in the very
    // cycle a frame starts wins over the older shadow copy. The raster
    // counters freeze on the last pixel so x and y never leave the screen.
    always_ff @(posedge clock) begin
        if (reset) begin
            x            <= '0;
            y            <= '0;
            render_state <= '0;
            shadow       <= '0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            pixel_first  <= 1'b0;
            pixel_eol    <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= '0;
        end else begin
            frame_done <= 1'b0;

            if (state_valid) begin
                shadow <= cube_state;
            end

            if (frame_start) begin
                x            <= '0;
                y            <= '0;
                render_state <= state_valid ? cube_state : shadow;
            end

            if (pixel_load) begin
                pixel_data  <= pixel_in;
                pixel_valid <= 1'b1;
                pixel_first <= (x == 9'd0) && (y == 8'd0);
                pixel_eol   <= (x == X_LAST);
                if (!last_pixel) begin
                    if (x == X_LAST) begin
                        x <= '0;
                        y <= y + 8'd1;
                    end else begin
                        x <= x + 9'd1;
                    end
                end
            end

            if (drain_ack) begin
                pixel_valid <= 1'b0;
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// tb_lcd_frame_scheduler
//
// Self-checking bench for lcd_frame_scheduler, run on a reduced 5x3 raster so
// that hundreds of frames fit in a short run. A frame-level reference model
// (linear pixel index, expected output registers) is compared against the DUT
// on every cycle, backed by handshake counters and a handful of literal
// expectations.
module tb_lcd_frame_scheduler;

    localparam int W = 5;
    localparam int H = 3;
    localparam int N = W * H;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [143:0] cube_state = '0;
    logic         state_valid = 1'b0;
    logic         start = 1'b0;
    logic         auto_refresh = 1'b0;
    logic [8:0]   x;
    logic [7:0]   y;
    logic [143:0] render_state;
    logic [15:0]  pixel_in;
    logic [15:0]  pixel_data;
    logic         pixel_valid;
    logic         pixel_ready = 1'b0;
    logic         pixel_first;
    logic         pixel_eol;
    logic         busy;
    logic         frame_done;
    logic [7:0]   frame_count;

    int check_count = 0;
    int pass_count  = 0;

    lcd_frame_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock        (clock),
        .reset        (reset),
        .cube_state   (cube_state),
        .state_valid  (state_valid),
        .start        (start),
        .auto_refresh (auto_refresh),
        .x            (x),
        .y            (y),
        .render_state (render_state),
        .pixel_in     (pixel_in),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .pixel_first  (pixel_first),
        .pixel_eol    (pixel_eol),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_count  (frame_count)
    );

    always #5 clock = ~clock;

    // Stand-in for the square renderer: a cheap mix of coordinate and state.
    function automatic logic [15:0] pixelOf(input int xx, input int yy, input logic [143:0] r);
        return r[15:0] ^ r[143:128] ^ {8'(yy), 8'(xx)};
    endfunction

    assign pixel_in = pixelOf(int'(x), int'(y), render_state);

    function automatic logic [143:0] randCube();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[143:0];
    endfunction

    task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. A frame is a run of N pixels identified by a linear
    // index; the expected output registers are updated from that index with
    // plain division/modulo. m_idx == N means every pixel has been loaded and
    // only the final acceptance is outstanding.
    int           m_idx = 0;
    bit           m_busy = 1'b0;
    logic         m_valid = 1'b0;
    logic         m_first = 1'b0;
    logic         m_eol = 1'b0;
    logic         m_done = 1'b0;
    logic [15:0]  m_data = '0;
    logic [7:0]   m_count = '0;
    logic [143:0] m_render = '0;
    logic [143:0] m_shadow = '0;
    logic [143:0] m_pick;

    always @(posedge clock) begin
        if (reset) begin
            m_idx = 0; m_busy = 0; m_valid = 0; m_first = 0; m_eol = 0;
            m_done = 0; m_data = '0; m_count = '0; m_render = '0; m_shadow = '0;
        end else begin
            m_pick = state_valid ? cube_state : m_shadow;
            if (state_valid) m_shadow = cube_state;
            m_done = 0;
            if (!m_busy) begin
                if (start || auto_refresh) begin
                    m_busy = 1; m_idx = 0; m_render = m_pick;
                end
            end else if (m_idx < N) begin
                if (!m_valid || pixel_ready) begin
                    m_data  = pixelOf(m_idx % W, m_idx / W, m_render);
                    m_valid = 1;
                    m_first = (m_idx == 0);
                    m_eol   = ((m_idx % W) == W - 1);
                    m_idx++;
                end
            end else if (pixel_ready) begin
                m_valid = 0; m_done = 1; m_count++;
                if (auto_refresh) begin
                    m_idx = 0; m_render = m_pick;
                end else begin
                    m_busy = 0;
                end
            end
        end
    end

    // Handshake bookkeeping, independent of the model: position of first/eol
    // within the frame, and snapshots used to prove stability under stall.
    int          hs_count = 0;
    int          eol_count = 0;
    int          first_count = 0;
    bit          stall_held = 1'b0;
    logic [15:0] snap_data;
    logic        snap_first;
    logic        snap_eol;

    always @(posedge clock) begin
        if (reset || frame_done) begin
            hs_count = 0; eol_count = 0; first_count = 0;
        end
        stall_held = !reset && pixel_valid && !pixel_ready;
        snap_data  = pixel_data;
        snap_first = pixel_first;
        snap_eol   = pixel_eol;
        if (!reset && pixel_valid && pixel_ready) begin
            checkOutput("eol_position", 144'(pixel_eol), 144'((hs_count % W) == W - 1));
            checkOutput("first_position", 144'(pixel_first), 144'(hs_count == 0));
            eol_count   += int'(pixel_eol);
            first_count += int'(pixel_first);
            hs_count++;
        end
    end

    // Per-cycle compare of every output against the model.
    logic [8:0] exp_x;
    logic [7:0] exp_y;

    always @(negedge clock) begin
        exp_x = (m_idx < N) ? 9'(m_idx % W) : 9'(W - 1);
        exp_y = (m_idx < N) ? 8'(m_idx / W) : 8'(H - 1);
        checkOutput("x", 144'(x), 144'(exp_x));
        checkOutput("y", 144'(y), 144'(exp_y));
        checkOutput("busy", 144'(busy), 144'(m_busy));
        checkOutput("pixel_valid", 144'(pixel_valid), 144'(m_valid));
        checkOutput("pixel_data", 144'(pixel_data), 144'(m_data));
        checkOutput("pixel_first", 144'(pixel_first), 144'(m_first));
        checkOutput("pixel_eol", 144'(pixel_eol), 144'(m_eol));
        checkOutput("frame_done", 144'(frame_done), 144'(m_done));
        checkOutput("frame_count", 144'(frame_count), 144'(m_count));
        checkOutput("render_state", render_state, m_render);
        if (stall_held) begin
            checkOutput("stall_data", 144'(pixel_data), 144'(snap_data));
            checkOutput("stall_first", 144'(pixel_first), 144'(snap_first));
            checkOutput("stall_eol", 144'(pixel_eol), 144'(snap_eol));
        end
        if (frame_done) begin
            checkOutput("frame_handshakes", 144'(hs_count), 144'(N));
            checkOutput("frame_eol_count", 144'(eol_count), 144'(H));
            checkOutput("frame_first_count", 144'(first_count), 144'(1));
        end
    end

    // Drive the inputs for the coming cycle (called just after a negedge).
    task automatic applyStimulus(input int ready_pct, input bit sv_random);
        pixel_ready = ($urandom_range(99) < ready_pct);
        if (sv_random) begin
            state_valid = ($urandom_range(5) == 0);
            cube_state  = randCube();
        end else begin
            state_valid = 1'b0;
        end
    endtask

    task automatic doReset();
        reset = 1'b1; start = 1'b1; auto_refresh = 1'b1;
        state_valid = 1'b1; cube_state = randCube(); pixel_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkOutput("rst_busy", 144'(busy), 144'(0));
        checkOutput("rst_x", 144'(x), 144'(0));
        checkOutput("rst_y", 144'(y), 144'(0));
        checkOutput("rst_valid", 144'(pixel_valid), 144'(0));
        checkOutput("rst_data", 144'(pixel_data), 144'(0));
        checkOutput("rst_first_eol", 144'({pixel_first, pixel_eol}), 144'(0));
        checkOutput("rst_done", 144'(frame_done), 144'(0));
        checkOutput("rst_count", 144'(frame_count), 144'(0));
        checkOutput("rst_render", render_state, 144'(0));
        reset = 1'b0; start = 1'b0; auto_refresh = 1'b0; state_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget, input int ready_pct, input bit sv_random);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clock);
            n++;
            if (frame_done) seen = 1'b1;
            else applyStimulus(ready_pct, sv_random);
        end
        if (!seen) checkOutput("frame_done_timeout", 144'(0), 144'(1));
    endtask

    task automatic waitXY(input int xx, input int yy, input int budget);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clock);
            n++;
            if (pixel_valid && int'(x) == xx && int'(y) == yy) seen = 1'b1;
            else applyStimulus(100, 1'b0);
        end
        if (!seen) checkOutput("xy_timeout", 144'(0), 144'(1));
    endtask

    logic [143:0] val_c0, val_a, val_b, val_c;

    initial begin
        // Reset, then a single frame with the writer always ready.
        doReset();
        start = 1'b1; pixel_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("t1_x0", 144'(x), 144'(0));
        checkOutput("t1_y0", 144'(y), 144'(0));
        checkOutput("t1_busy", 144'(busy), 144'(1));
        checkOutput("t1_valid_c1", 144'(pixel_valid), 144'(0));
        checkOutput("t1_render_zero", render_state, 144'(0));
        @(negedge clock);
        checkOutput("t1_valid_c2", 144'(pixel_valid), 144'(1));
        checkOutput("t1_first_c2", 144'(pixel_first), 144'(1));
        checkOutput("t1_data_c2", 144'(pixel_data), 144'(16'h0000));
        checkOutput("t1_x_c2", 144'(x), 144'(1));
        waitDone(200, 100, 1'b0);
        checkOutput("t1_count", 144'(frame_count), 144'(1));
        @(negedge clock);
        checkOutput("t1_idle", 144'(busy), 144'(0));

        // Stall for five cycles with pixel (3,1) on the output.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitXY(4, 1, 100);
        pixel_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("t2_stall_x", 144'(x), 144'(4));
            checkOutput("t2_stall_y", 144'(y), 144'(1));
            checkOutput("t2_stall_data", 144'(pixel_data), 144'(16'h0103));
        end
        pixel_ready = 1'b1;
        waitDone(200, 100, 1'b0);
        checkOutput("t2_count", 144'(frame_count), 144'(2));

        // Frame-stable render_state.
        val_c0 = {16'h1234, 112'h0, 16'h00FF};
        val_a  = randCube();
        val_b  = randCube();
        val_c  = randCube();
        state_valid = 1'b1; cube_state = val_c0; start = 1'b1;
        @(negedge clock);
        state_valid = 1'b0; start = 1'b0; cube_state = randCube();
        checkOutput("t3_render_same_cycle", render_state, val_c0);
        @(negedge clock);
        checkOutput("t3_first", 144'(pixel_first), 144'(1));
        checkOutput("t3_first_data", 144'(pixel_data), 144'(16'h12CB));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(70, 1'b0);
            @(negedge clock);
        end
        state_valid = 1'b1; cube_state = val_a;
        @(negedge clock);
        state_valid = 1'b0; cube_state = randCube();
        checkOutput("t3_render_mid", render_state, val_c0);
        waitDone(300, 70, 1'b0);
        checkOutput("t3_render_end", render_state, val_c0);
        state_valid = 1'b1; cube_state = val_b;
        @(negedge clock);
        state_valid = 1'b0; cube_state = randCube(); start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("t3_render_b", render_state, val_b);
        waitDone(300, 70, 1'b0);
        state_valid = 1'b1; cube_state = val_c; start = 1'b1;
        @(negedge clock);
        state_valid = 1'b0; start = 1'b0; cube_state = randCube();
        checkOutput("t3_render_c", render_state, val_c);
        waitDone(300, 70, 1'b0);
        checkOutput("t3_count", 144'(frame_count), 144'(5));

        // Three back-to-back frames under auto_refresh.
        doReset();
        auto_refresh = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            waitDone(300, 70, 1'b1);
            checkOutput("t4_busy_at_done", 144'(busy), 144'(1));
            checkOutput("t4_count", 144'(frame_count), 144'(f));
        end
        auto_refresh = 1'b0;

        // start held while busy, then reset mid-frame.
        doReset();
        pixel_ready = 1'b1; start = 1'b1;
        waitXY(2, 1, 100);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        checkOutput("t5_busy", 144'(busy), 144'(0));
        checkOutput("t5_xy", 144'({x, y}), 144'(0));
        checkOutput("t5_valid", 144'(pixel_valid), 144'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("t5_no_done", 144'(frame_done), 144'(0));
            checkOutput("t5_count", 144'(frame_count), 144'(0));
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("t5_restart_x", 144'(x), 144'(0));
        checkOutput("t5_restart_y", 144'(y), 144'(0));
        checkOutput("t5_restart_busy", 144'(busy), 144'(1));
        waitDone(200, 80, 1'b1);
        checkOutput("t5_count_after", 144'(frame_count), 144'(1));

        // frame_count wrap.
        doReset();
        auto_refresh = 1'b1;
        for (int f = 0; f < 255; f++) begin
            waitDone(100, 90, 1'b1);
        end
        checkOutput("t6_count_255", 144'(frame_count), 144'(255));
        waitDone(100, 90, 1'b1);
        checkOutput("t6_count_wrap", 144'(frame_count), 144'(0));
        auto_refresh = 1'b0;
        @(negedge clock);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
